piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx_pkg.sv | 5 +
 rtl/piso_tx_bit_timer.sv | 18 +
 rtl/piso_tx.sv | 88 ++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared FSM states and line constants for piso_tx
package piso_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/piso_tx_bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 while enabled, tick on the wrap cycle
module bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = enable && cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-to-serial transmitter; define PISO_TX_PARITY_EN for an even-parity bit
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic sout_q, sout_d, tick, last_bit, par_bit;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q != IDLE),
    .tick  (tick)
  );
  assign last_bit = idx_q == IW'(WIDTH - 1);
`ifdef PISO_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d   = (state_q == IDLE && in_valid) ? ^in : par_q;
  assign par_bit = par_d;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`else
  assign par_bit = IDLE_LEVEL;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sout_q  <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = START;
        shift_d = in;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        idx_d   = last_bit ? '0 : idx_q + 1'b1;
`ifdef PISO_TX_PARITY_EN
        if (last_bit) state_d = PARITY;
`else
        if (last_bit) state_d = STOP;
`endif
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sout_d   = state_d == START  ? 1'b0 :
               state_d == DATA   ? shift_d[0] :
               state_d == PARITY ? par_bit : IDLE_LEVEL;
    in_ready = state_q == IDLE;
    busy     = state_q != IDLE;
    done     = state_q == STOP && tick;
    sout     = sout_q;
  end
endmodule
